fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage sitting directly downstream of the program-counter register and upstream of decode. Presents the current PC to instruction memory, captures the returned instruction into the IF/ID pipeline register, and drives the PC register's `stall` input whenever the fetched instruction cannot be accepted. A one-entry skid buffer absorbs a fetch that completes while decode is stalled. A branch/jump `flush` squashes everything in flight.

## Interface
- `NOP_INSTR`, default 32'h0000_0013, encoding driven on `if_id_instr` whenever `if_id_valid`=0
- `CNT_W`, default 32, width of the performance counters
- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-low reset (asserted when 0)
- `pc_in`  input  32  `current_pc` from the PC register
- `pc_stall`  output  1  to PC register `stall`; 1 = hold PC
- `imem_req`  output  1  fetch request
- `imem_addr`  output  32  fetch address; combinationally equal to `pc_in`
- `imem_ack`  input  1  memory returns `imem_rdata` for `imem_addr` this cycle
- `imem_rdata`  input  32  instruction word, valid only when `imem_ack`=1
- `id_stall`  input  1  decode hazard; 1 = IF/ID must hold
- `flush`  input  1  redirect/squash from branch resolution
- `if_id_pc`  output  32  PC of the instruction in IF/ID
- `if_id_instr`  output  32  instruction in IF/ID
- `if_id_valid`  output  1  IF/ID holds a real instruction
- `fetch_count`  output  CNT_W  instructions accepted from memory; wraps
- `stall_count`  output  CNT_W  cycles with `pc_stall`=1; wraps

## Operation
- Two states: RUN (skid empty) and HOLD (skid full). Reset state is RUN.
- Reset values: `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=NOP_INSTR, skid empty, both counters 0.
- **RUN**
  - `imem_req`=1.
  - Priority 1, `flush`=1:
    - IF/ID valid←0 and instr←NOP_INSTR.
    - Response ignored.
    - `pc_stall`=0, so the PC loads the redirect target.
    - Stay in RUN.
  - Priority 2, `imem_ack`=1 and (`if_id_valid`=0 or `id_stall`=0):
    - IF/ID←{`pc_in`, `imem_rdata`, 1}.
    - `pc_stall`=0.
    - `fetch_count`+1.
  - Priority 3, `imem_ack`=1 and `if_id_valid`=1 and `id_stall`=1:
    - skid←{`pc_in`, `imem_rdata`}.
    - `pc_stall`=0.
    - `fetch_count`+1.
    - Go to HOLD. IF/ID unchanged.
  - Priority 4, `imem_ack`=0:
    - `pc_stall`=1.
    - If `id_stall`=0, IF/ID valid←0 and instr←NOP_INSTR (bubble). Otherwise IF/ID holds.
- **HOLD**
  - `imem_req`=0 and `pc_stall`=1, except on `flush`.
  - `flush`=1: IF/ID invalidated, skid discarded, `pc_stall`=0, go to RUN.
  - `id_stall`=0: IF/ID←{skid pc, skid instr, 1}, go to RUN.
  - Otherwise: hold everything.
- `if_id_instr` equals NOP_INSTR whenever `if_id_valid`=0.
- `id_stall` with `if_id_valid`=0 does not block a capture. An empty register is always writable.
- `flush` overrides `id_stall` and `imem_ack` in the same cycle.
- `stall_count` increments on every cycle with `pc_stall`=1.
- Both counters wrap modulo 2^CNT_W.

## Timing
- `pc_stall`, `imem_req` and `imem_addr` are combinational from state and inputs. There is no register between `pc_in` and `imem_addr`.
- Fetch latency: `imem_ack` at edge t puts the instruction on IF/ID outputs after edge t; the PC advances at the same edge.
- Throughput: 1 instruction/cycle while `imem_ack`=1 and `id_stall`=0.
- After a HOLD→RUN transition, the next fetch is issued in the following cycle.
- `flush` at edge t: IF/ID is invalid after t. The first redirected fetch can be acked in cycle t+1.
- Reset asserted mid-operation: all outputs return to reset values immediately. The skid is emptied and any pending response is dropped.
- First fetch after reset release is at `pc_in`=0.

## Test plan
- **Streaming:** release reset, `imem_ack`=1 every cycle, rdata=0x100+pc. Required: IF/ID shows pc 0,4,8… one per cycle. `pc_stall`=0 throughout. `fetch_count`=N after N cycles.
- **Memory wait:** ack low 3 cycles at pc=8. Required:
  - `pc_stall`=1 for 3 cycles; `stall_count`=3.
  - 3 bubbles with `if_id_instr`=0x00000013.
  - pc 8 appears after the ack edge.
- **Skid:** IF/ID holds pc 4; assert `id_stall` while ack returns pc 8. Required:
  - IF/ID stays at pc 4, state HOLD, `pc_stall`=1, `imem_req`=0.
  - Drop `id_stall`: pc 8 enters IF/ID, then pc 12 fetched next cycle.
- **Flush priority:** `flush`=1 with `imem_ack`=1 and `id_stall`=1 in HOLD. Required: `if_id_valid`=0, skid discarded, `pc_stall`=0, state RUN, `fetch_count` unchanged.
- **Async reset mid-HOLD:** pull `rst` low between edges. Required: `if_id_valid`=0, `if_id_pc`=0, counters 0, state RUN, before the next clock edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage
// (master) and instruction memory (slave).
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: presents the PC to instruction memory, fills IF/ID,
// and parks one completed fetch in a skid entry while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_in_i,
  output logic             pc_stall_o,
  fetch_stage_if.master    imem,
  input  logic             id_stall_i,
  input  logic             flush_i,
  output logic [31:0]      if_id_pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] fetch_count_o,
  output logic [CNT_W-1:0] stall_count_o
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t             state_q, state_d;
  logic [31:0]        ifid_pc_q, ifid_pc_d;
  logic [31:0]        ifid_instr_q, ifid_instr_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [31:0]        skid_pc_q, skid_pc_d;
  logic [31:0]        skid_instr_q, skid_instr_d;
  logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               req;
  logic               pc_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= NOP_INSTR;
      fetch_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      fetch_cnt_q  <= fetch_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    fetch_cnt_d  = fetch_cnt_q;
    req          = 1'b1;
    pc_stall     = 1'b0;

    case (state_q)
      RUN: begin
        if (flush_i) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end else if (imem.ack) begin
          fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
          // An empty IF/ID is always writable, even under a decode stall.
          if (!ifid_valid_q || !id_stall_i) begin
            ifid_pc_d    = pc_in_i;
            ifid_instr_d = imem.rdata;
            ifid_valid_d = 1'b1;
          end else begin
            skid_pc_d    = pc_in_i;
            skid_instr_d = imem.rdata;
            state_d      = HOLD;
          end
        end else begin
          pc_stall = 1'b1;
          if (!id_stall_i) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
          end
        end
      end
      HOLD: begin
        if (flush_i) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          state_d      = RUN;
        end else begin
          req      = 1'b0;
          pc_stall = 1'b1;
          if (!id_stall_i) begin
            ifid_pc_d    = skid_pc_q;
            ifid_instr_d = skid_instr_q;
            ifid_valid_d = 1'b1;
            state_d      = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall);
  end

  assign imem.req      = req;
  assign imem.addr     = pc_in_i;
  assign pc_stall_o    = pc_stall;
  assign if_id_pc_o    = ifid_pc_q;
  assign if_id_instr_o = ifid_instr_q;
  assign if_id_valid_o = ifid_valid_q;
  assign fetch_count_o = fetch_cnt_q;
  assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a queue model of IF/ID plus skid (front = IF/ID) is
// compared with the DUT every cycle, alongside hand-computed literal checks.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          CW  = 4;
  localparam int          CNT_MASK = (1 << CW) - 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   pcReg;
  logic          idStall;
  logic          flushIn;
  logic [31:0]   flushTarget;
  logic          pcStall;
  logic [31:0]   ifIdPc;
  logic [31:0]   ifIdInstr;
  logic          ifIdValid;
  logic [CW-1:0] fetchCount;
  logic [CW-1:0] stallCount;

  fetch_stage_if imemBus();

  fetch_stage #(.NOP_INSTR(NOP), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_in_i       (pcReg),
    .pc_stall_o    (pcStall),
    .imem          (imemBus),
    .id_stall_i    (idStall),
    .flush_i       (flushIn),
    .if_id_pc_o    (ifIdPc),
    .if_id_instr_o (ifIdInstr),
    .if_id_valid_o (ifIdValid),
    .fetch_count_o (fetchCount),
    .stall_count_o (stallCount)
  );

  always #5 clk = ~clk;

  int    checkCount = 0;
  int    failCount  = 0;
  item_t mq[$];
  int    fetchModel;
  int    stallModel;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // PC holds unless redirecting, and only when the fetch cannot complete
  // or a parked instruction already occupies the skid.
  function automatic logic expStall();
    return !flushIn && (mq.size() == 2 || !imemBus.ack);
  endfunction

  function automatic logic expReq();
    return flushIn || (mq.size() < 2);
  endfunction

  task automatic resetModel();
    mq.delete();
    fetchModel = 0;
    stallModel = 0;
    pcReg      = 32'h0;
  endtask

  task automatic driveInputs(input logic ack, input logic stl, input logic fl, input logic [31:0] tgt);
    imemBus.ack   = ack;
    imemBus.rdata = ack ? (32'h100 + pcReg) : 32'hDEAD_BEEF;
    idStall       = stl;
    flushIn       = fl;
    flushTarget   = tgt;
    #2;
  endtask

  task automatic checkOutput();
    checkValue("if_id_valid", {31'b0, ifIdValid}, {31'b0, mq.size() > 0});
    checkValue("if_id_instr", ifIdInstr, (mq.size() > 0) ? mq[0].instr : NOP);
    if (mq.size() > 0) checkValue("if_id_pc", ifIdPc, mq[0].pc);
    checkValue("pc_stall", {31'b0, pcStall}, {31'b0, expStall()});
    checkValue("imem_req", {31'b0, imemBus.req}, {31'b0, expReq()});
    checkValue("imem_addr", imemBus.addr, pcReg);
    checkValue("fetch_count", 32'(fetchCount), 32'(fetchModel & CNT_MASK));
    checkValue("stall_count", 32'(stallCount), 32'(stallModel & CNT_MASK));
  endtask

  task automatic clockModel();
    logic  stl;
    logic  acc;
    item_t it;
    stl = expStall();
    acc = expReq() && imemBus.ack && !flushIn;
    it  = '{pc: pcReg, instr: imemBus.rdata};
    @(posedge clk);
    #1;
    if (flushIn) begin
      mq.delete();
    end else begin
      if (!idStall && mq.size() > 0) void'(mq.pop_front());
      if (acc) mq.push_back(it);
    end
    if (acc) fetchModel++;
    if (stl) stallModel++;
    if (flushIn)   pcReg = flushTarget;
    else if (!stl) pcReg = pcReg + 32'd4;
  endtask

  task automatic applyStimulus(input logic ack, input logic stl, input logic fl, input logic [31:0] tgt);
    driveInputs(ack, stl, fl, tgt);
    checkOutput();
    clockModel();
    @(negedge clk);
  endtask

  typedef struct packed {
    logic        ack;
    logic        stl;
    logic        fl;
    logic [31:0] tgt;
  } vec_t;

  vec_t mixed[12];

  initial begin
    mixed[0]  = '{1'b1, 1'b1, 1'b0, 32'h0};
    mixed[1]  = '{1'b0, 1'b1, 1'b0, 32'h0};
    mixed[2]  = '{1'b0, 1'b0, 1'b0, 32'h0};
    mixed[3]  = '{1'b1, 1'b0, 1'b0, 32'h0};
    mixed[4]  = '{1'b1, 1'b0, 1'b1, 32'h400};
    mixed[5]  = '{1'b1, 1'b1, 1'b0, 32'h0};
    mixed[6]  = '{1'b1, 1'b1, 1'b0, 32'h0};
    mixed[7]  = '{1'b0, 1'b0, 1'b0, 32'h0};
    mixed[8]  = '{1'b1, 1'b0, 1'b0, 32'h0};
    mixed[9]  = '{1'b0, 1'b1, 1'b0, 32'h0};
    mixed[10] = '{1'b1, 1'b1, 1'b1, 32'h500};
    mixed[11] = '{1'b1, 1'b0, 1'b0, 32'h0};

    rst_n         = 1'b0;
    imemBus.ack   = 1'b0;
    imemBus.rdata = 32'h0;
    idStall       = 1'b0;
    flushIn       = 1'b0;
    flushTarget   = 32'h0;
    resetModel();
    #12;
    @(negedge clk);
    rst_n = 1'b1;

    checkValue("reset if_id_valid", {31'b0, ifIdValid}, 32'h0);
    checkValue("reset if_id_pc", ifIdPc, 32'h0);
    checkValue("reset if_id_instr", ifIdInstr, 32'h0000_0013);
    checkValue("reset fetch_count", 32'(fetchCount), 32'h0);
    checkValue("reset stall_count", 32'(stallCount), 32'h0);
    checkValue("first imem_addr", imemBus.addr, 32'h0);

    // Streaming pc 0, 4
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkValue("stream if_id_pc", ifIdPc, 32'h4);
    checkValue("stream if_id_instr", ifIdInstr, 32'h104);
    checkValue("stream fetch_count", 32'(fetchCount), 32'd2);

    // Memory wait at pc 8
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkValue("wait stall_count", 32'(stallCount), 32'd3);
    checkValue("wait bubble valid", {31'b0, ifIdValid}, 32'h0);
    checkValue("wait bubble instr", ifIdInstr, 32'h0000_0013);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkValue("wait pc8 arrives", ifIdPc, 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    // Skid: IF/ID holds 12, pc 16 parked
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    driveInputs(1'b1, 1'b1, 1'b0, 32'h0);
    checkValue("skid pc_stall", {31'b0, pcStall}, 32'h1);
    checkValue("skid imem_req", {31'b0, imemBus.req}, 32'h0);
    checkValue("skid if_id_pc held", ifIdPc, 32'hC);
    checkOutput();
    clockModel();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkValue("skid drains pc16", ifIdPc, 32'h10);
    checkValue("skid drains instr", ifIdInstr, 32'h110);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkValue("after skid pc20", ifIdPc, 32'h14);

    // Flush in HOLD with ack and id_stall also high
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkValue("pre-flush fetch_count", 32'(fetchCount), 32'd7);
    driveInputs(1'b1, 1'b1, 1'b1, 32'h200);
    checkValue("flush pc_stall", {31'b0, pcStall}, 32'h0);
    checkOutput();
    clockModel();
    @(negedge clk);
    checkValue("flush if_id_valid", {31'b0, ifIdValid}, 32'h0);
    checkValue("flush if_id_instr", ifIdInstr, 32'h0000_0013);
    checkValue("flush fetch_count", 32'(fetchCount), 32'd7);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkValue("redirect if_id_pc", ifIdPc, 32'h200);
    checkValue("redirect if_id_instr", ifIdInstr, 32'h300);

    for (int i = 0; i < 12; i++) applyStimulus(mixed[i].ack, mixed[i].stl, mixed[i].fl, mixed[i].tgt);

    // Async reset between edges while in HOLD
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    driveInputs(1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    checkValue("async if_id_valid", {31'b0, ifIdValid}, 32'h0);
    checkValue("async if_id_pc", ifIdPc, 32'h0);
    checkValue("async if_id_instr", ifIdInstr, 32'h0000_0013);
    checkValue("async fetch_count", 32'(fetchCount), 32'h0);
    checkValue("async stall_count", 32'(stallCount), 32'h0);
    checkValue("async state RUN req", {31'b0, imemBus.req}, 32'h1);
    resetModel();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Long stream to wrap the narrow counters
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkValue("wrap fetch_count", 32'(fetchCount), 32'd4);
    checkValue("wrap if_id_pc", ifIdPc, 32'd76);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
